// File: rtl/pdm_deserializer_multi_pkg.sv
// Shared types and defaults for the PDM mic deserializer.
package pdm_pkg;

    typedef enum logic {CH_L = 1'b0, CH_R = 1'b1} pdm_chan_e;

    localparam int PDM_CLK_DIV_DEFAULT = 50;
    localparam int PDM_WORD_W_DEFAULT  = 16;

endpackage

// File: rtl/pdm_deserializer_multi_if.sv
// Word stream leaving the deserializer: head word, its channel, valid/ready.
interface pdm_deserializer_multi_if #(
    parameter int WORD_W = 16
) ();
    logic [WORD_W-1:0] data;
    logic              chan;
    logic              valid;
    logic              ready;

    modport master (output data, output chan, output valid, input ready);
    modport slave  (input data, input chan, input valid, output ready);
endinterface

// File: rtl/pdm_word_fifo.sv
// Small synchronous FIFO for assembled words; a pop frees a slot for a same-cycle push.
module pdm_word_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clock_i,
    input  logic         rst_n_i,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp_q, rp_q;
    logic         do_pop, do_push;

    // extra pointer bit tells full from empty when the indices match
    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp_q[AW-1:0]];

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wp_q <= '0;
            rp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp_q[AW-1:0]] <= push_data;
                wp_q              <= wp_q + 1'b1;
            end
            if (do_pop) rp_q <= rp_q + 1'b1;
        end
    end
endmodule

// File: rtl/pdm_deserializer_multi.sv
// PDM mic clock generator and mono/stereo sample deserializer feeding a word FIFO.
module pdm_deserializer_multi
    import pdm_pkg::*;
#(
    parameter int CLK_DIV    = PDM_CLK_DIV_DEFAULT,
    parameter int WORD_W     = PDM_WORD_W_DEFAULT,
    parameter int STEREO     = 0,
    parameter int MSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clock_i,
    input  logic rst_n_i,
    input  logic enable_i,
    input  logic pdm_data_i,
    output logic pdm_clk_o,
    output logic pdm_lrsel_o,
    output logic overrun_o,
    pdm_deserializer_multi_if.master out_if
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(WORD_W);
    localparam int NSLOT = (STEREO != 0) ? 2 : 1;

    logic [DIV_W-1:0]  div_q;
    logic              tc;
    logic [WORD_W-1:0] slot_word [NSLOT];
    logic [NSLOT-1:0]  slot_done;
    logic              push, fifo_full, fifo_empty, fifo_pop, drop;
    logic [WORD_W:0]   push_data, head;

    assign pdm_lrsel_o = (STEREO == 0);
    assign tc          = enable_i && (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q     <= '0;
            pdm_clk_o <= 1'b0;
        end else if (!enable_i) begin
            div_q     <= '0;
            pdm_clk_o <= 1'b0;
        end else if (tc) begin
            div_q     <= '0;
            pdm_clk_o <= ~pdm_clk_o;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    for (genvar s = 0; s < NSLOT; s++) begin : g_slot
        logic              stb, last, done_q;
        logic [WORD_W-1:0] sr_q;
        logic [CNT_W-1:0]  cnt_q;

        // slot 0 (R) samples as the mic clock rises, slot 1 (L) as it falls
        if (s == 0) begin : g_r
            assign stb = tc && !pdm_clk_o;
        end else begin : g_l
            assign stb = tc && pdm_clk_o;
        end

        assign last = (cnt_q == CNT_W'(WORD_W - 1));

        always_ff @(posedge clock_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                sr_q   <= '0;
                cnt_q  <= '0;
                done_q <= 1'b0;
            end else if (!enable_i) begin
                sr_q   <= '0;
                cnt_q  <= '0;
                done_q <= 1'b0;
            end else begin
                done_q <= stb && last;
                if (stb) begin
                    sr_q  <= (MSB_FIRST != 0) ? {sr_q[WORD_W-2:0], pdm_data_i}
                                              : {pdm_data_i, sr_q[WORD_W-1:1]};
                    cnt_q <= last ? '0 : cnt_q + 1'b1;
                end
            end
        end

        assign slot_word[s] = sr_q;
        assign slot_done[s] = done_q;
    end

    // the two slots never complete in the same cycle, so a simple priority mux suffices
    assign push      = |slot_done;
    assign push_data = slot_done[0] ? {CH_R, slot_word[0]} : {CH_L, slot_word[NSLOT-1]};
    assign fifo_pop  = out_if.ready && !fifo_empty;
    assign drop      = push && fifo_full && !fifo_pop;

    pdm_word_fifo #(.W(WORD_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_i  (clock_i),
        .rst_n_i  (rst_n_i),
        .push     (push),
        .push_data(push_data),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .head     (head),
        .empty    (fifo_empty)
    );

    assign out_if.valid = !fifo_empty;
    assign out_if.data  = head[WORD_W-1:0];
    assign out_if.chan  = head[WORD_W];

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i)       overrun_o <= 1'b0;
        else if (!enable_i) overrun_o <= 1'b0;
        else if (drop)      overrun_o <= 1'b1;
    end
endmodule

// File: tb/tb_pdm_deserializer_multi.sv
// Three deserializers (mono MSB-first, stereo, mono LSB-first) run in lockstep against a cycle-level model.
module tb_pdm_deserializer_multi;
    localparam int D = 2, W = 8, DEP = 4, N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, enable, ready;
    logic [N-1:0] pdm_d, pclk, lrsel, ovr, o_vld, o_chn;
    logic [W-1:0] o_dat [N];

    pdm_deserializer_multi_if #(.WORD_W(W)) if0 ();
    pdm_deserializer_multi_if #(.WORD_W(W)) if1 ();
    pdm_deserializer_multi_if #(.WORD_W(W)) if2 ();
    assign if0.ready = ready;
    assign if1.ready = ready;
    assign if2.ready = ready;
    assign o_vld = {if2.valid, if1.valid, if0.valid};
    assign o_chn = {if2.chan, if1.chan, if0.chan};
    assign o_dat[0] = if0.data;
    assign o_dat[1] = if1.data;
    assign o_dat[2] = if2.data;

    pdm_deserializer_multi #(.CLK_DIV(D), .WORD_W(W), .STEREO(0), .MSB_FIRST(1), .FIFO_DEPTH(DEP)) u_mono (
        .clock_i(clk), .rst_n_i(rst_n), .enable_i(enable), .pdm_data_i(pdm_d[0]),
        .pdm_clk_o(pclk[0]), .pdm_lrsel_o(lrsel[0]), .overrun_o(ovr[0]), .out_if(if0));
    pdm_deserializer_multi #(.CLK_DIV(D), .WORD_W(W), .STEREO(1), .MSB_FIRST(1), .FIFO_DEPTH(DEP)) u_st (
        .clock_i(clk), .rst_n_i(rst_n), .enable_i(enable), .pdm_data_i(pdm_d[1]),
        .pdm_clk_o(pclk[1]), .pdm_lrsel_o(lrsel[1]), .overrun_o(ovr[1]), .out_if(if1));
    pdm_deserializer_multi #(.CLK_DIV(D), .WORD_W(W), .STEREO(0), .MSB_FIRST(0), .FIFO_DEPTH(DEP)) u_lsb (
        .clock_i(clk), .rst_n_i(rst_n), .enable_i(enable), .pdm_data_i(pdm_d[2]),
        .pdm_clk_o(pclk[2]), .pdm_lrsel_o(lrsel[2]), .overrun_o(ovr[2]), .out_if(if2));

    // reference model: enabled-cycle count n decides the strobes, words are lists of placed bits
    int           n_en, vectors, fails;
    logic         mpclk;
    logic [W-1:0] acc_r [N], acc_l [N];
    int           cnt_r [N], cnt_l [N];
    logic [W:0]   mf [N][DEP];
    int           mc [N];
    logic         pv [N], movr [N];
    logic [W:0]   pw [N];
    logic [W-1:0] fr_w [N], fl_w [N];
    int           fr_n [N], fl_n [N];

    function automatic bit is_st(int d);  return d == 1; endfunction
    function automatic bit is_msb(int d); return d != 2; endfunction

    task automatic chk(input string tag, input int d, input logic [W:0] obs, input logic [W:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_clear();
        n_en  = 0;
        mpclk = 1'b0;
        for (int d = 0; d < N; d++) begin
            acc_r[d] = '0; acc_l[d] = '0; cnt_r[d] = 0; cnt_l[d] = 0;
            mc[d] = 0; pv[d] = 1'b0; movr[d] = 1'b0; pw[d] = '0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < N; d++) begin
            chk("valid", d, (W+1)'(o_vld[d]), (W+1)'(mc[d] > 0));
            if (mc[d] > 0) begin
                chk("data", d, (W+1)'(o_dat[d]), (W+1)'(mf[d][0][W-1:0]));
                chk("chan", d, (W+1)'(o_chn[d]), (W+1)'(mf[d][0][W]));
            end
            chk("overrun", d, (W+1)'(ovr[d]), (W+1)'(movr[d]));
            chk("pdm_clk", d, (W+1)'(pclk[d]), (W+1)'(mpclk));
        end
    endtask

    task automatic model_edge(input bit rstb, input bit lstb);
        int pos;
        for (int d = 0; d < N; d++) begin
            if (ready && mc[d] > 0) begin
                for (int i = 0; i < DEP - 1; i++) mf[d][i] = mf[d][i+1];
                mc[d]--;
            end
            if (pv[d]) begin
                if (mc[d] < DEP) begin mf[d][mc[d]] = pw[d]; mc[d]++; end
                else movr[d] = 1'b1;
                pv[d] = 1'b0;
            end
            if (enable) begin
                if (rstb) begin
                    pos = is_msb(d) ? W - 1 - cnt_r[d] : cnt_r[d];
                    acc_r[d][pos] = pdm_d[d];
                    cnt_r[d]++;
                    if (cnt_r[d] == W) begin pv[d] = 1'b1; pw[d] = {1'b1, acc_r[d]}; cnt_r[d] = 0; acc_r[d] = '0; end
                end
                if (lstb && is_st(d)) begin
                    pos = is_msb(d) ? W - 1 - cnt_l[d] : cnt_l[d];
                    acc_l[d][pos] = pdm_d[d];
                    cnt_l[d]++;
                    if (cnt_l[d] == W) begin pv[d] = 1'b1; pw[d] = {1'b0, acc_l[d]}; cnt_l[d] = 0; acc_l[d] = '0; end
                end
            end else begin
                acc_r[d] = '0; acc_l[d] = '0; cnt_r[d] = 0; cnt_l[d] = 0; movr[d] = 1'b0;
            end
        end
        if (enable) begin n_en++; mpclk = ((n_en / D) % 2) != 0; end
        else begin n_en = 0; mpclk = 1'b0; end
    endtask

    // one cycle: check at the negedge, drive data, let the posedge happen, advance the model
    task automatic step();
        bit rstb, lstb, b;
        check_all();
        rstb = rst_n && enable && (n_en % (2*D) == D - 1);
        lstb = rst_n && enable && (n_en % (2*D) == 2*D - 1);
        for (int d = 0; d < N; d++) begin
            b = 1'($urandom_range(0, 1));
            if (rstb && fr_n[d] > 0) begin b = fr_w[d][fr_n[d]-1]; fr_n[d]--; end
            if (lstb && is_st(d) && fl_n[d] > 0) begin b = fl_w[d][fl_n[d]-1]; fl_n[d]--; end
            pdm_d[d] = b;
        end
        @(posedge clk);
        if (!rst_n) model_clear();
        else model_edge(rstb, lstb);
        @(negedge clk);
    endtask

    initial begin
        vectors = 0; fails = 0;
        rst_n = 1'b0; enable = 1'b0; ready = 1'b0; pdm_d = '0;
        for (int d = 0; d < N; d++) begin fr_n[d] = 0; fl_n[d] = 0; fr_w[d] = '0; fl_w[d] = '0; end
        model_clear();
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            chk("rst_valid", d, (W+1)'(o_vld[d]), '0);
            chk("rst_data", d, (W+1)'(o_dat[d]), '0);
            chk("rst_chan", d, (W+1)'(o_chn[d]), '0);
            chk("rst_ovr", d, (W+1)'(ovr[d]), '0);
            chk("rst_pclk", d, (W+1)'(pclk[d]), '0);
        end
        chk("lrsel", 0, (W+1)'(lrsel[0]), 9'd1);
        chk("lrsel", 1, (W+1)'(lrsel[1]), 9'd0);
        rst_n = 1'b1;
        repeat (3) step();

        // directed words: A5 on both mono parts, R=3C / L=C3 on the stereo part
        fr_w[0] = 8'hA5; fr_w[1] = 8'h3C; fr_w[2] = 8'hA5; fl_w[1] = 8'hC3;
        for (int d = 0; d < N; d++) fr_n[d] = 8;
        fl_n[1] = 8;
        enable = 1'b1;
        repeat (36) step();
        chk("mono_word", 0, {o_chn[0], o_dat[0]}, 9'h1A5);
        chk("lsb_word", 2, {o_chn[2], o_dat[2]}, 9'h1A5);
        chk("st_head", 1, {o_chn[1], o_dat[1]}, 9'h13C);

        // stall until more than FIFO_DEPTH words have arrived, then drain
        repeat (140) step();
        chk("ovr_set", 0, (W+1)'(ovr[0]), 9'd1);
        chk("ovr_head", 0, (W+1)'(o_dat[0]), 9'h0A5);
        ready = 1'b1;
        repeat (8) step();
        chk("ovr_sticky", 0, (W+1)'(ovr[0]), 9'd1);
        enable = 1'b0;
        repeat (4) step();
        chk("ovr_clear", 0, (W+1)'(ovr[0]), 9'd0);

        // partial word (3 bits) discarded across a disable, then a fresh 5A
        enable = 1'b1;
        repeat (12) step();
        enable = 1'b0;
        repeat (3) step();
        chk("partial_dropped", 0, (W+1)'(o_vld[0]), 9'd0);
        fr_w[0] = 8'h5A; fr_n[0] = 8;
        ready = 1'b0;
        enable = 1'b1;
        repeat (36) step();
        chk("fresh_word", 0, (W+1)'(o_dat[0]), 9'h05A);
        ready = 1'b1;

        // randomized traffic with random backpressure and occasional enable drops
        repeat (300) begin
            ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            step();
        end

        // asynchronous reset mid-word with words queued
        enable = 1'b1; ready = 1'b0;
        for (int i = 0; i < 200 && mc[0] < 2; i++) step();
        repeat (5) step();
        chk("pre_rst_valid", 0, (W+1)'(o_vld[0]), 9'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < N; d++) begin
            chk("async_valid", d, (W+1)'(o_vld[d]), '0);
            chk("async_ovr", d, (W+1)'(ovr[d]), '0);
            chk("async_pclk", d, (W+1)'(pclk[d]), '0);
        end
        model_clear();
        enable = 1'b0;
        @(negedge clk);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("post_rst_data", 0, (W+1)'(o_dat[0]), '0);

        // 8'h01 bit sequence: MSB-first keeps 01, LSB-first gives 80
        fr_w[0] = 8'h01; fr_w[2] = 8'h01; fr_n[0] = 8; fr_n[2] = 8;
        enable = 1'b1;
        repeat (36) step();
        chk("msb_01", 0, (W+1)'(o_dat[0]), 9'h001);
        chk("lsb_80", 2, (W+1)'(o_dat[2]), 9'h080);
        ready = 1'b1;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
